// File: rtl/dco_freq_meter_pkg.sv
// dco_meas_pkg: shared types and helpers for the DCO frequency meter.
//   meas_state_e : measurement FSM state encoding
//   GATE_SEL_W   : width of the gate window select
//   gate_len()   : gate window length in clk cycles, 2^(log2+sel)
package dco_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } meas_state_e;

  localparam int GATE_SEL_W = 2;

  function automatic int unsigned gate_len(input int unsigned log2,
                                           input logic [GATE_SEL_W-1:0] sel);
    return 32'd1 << (log2 + 32'(sel));
  endfunction

endpackage

// File: rtl/dco_freq_meter_if.sv
// dco_freq_meter_if: control/result bundle between the frequency meter and its
// consumer (top-level readout mux or characterisation logic).
//   start, cont, gate_sel  : measurement request, continuous mode, window select
//   result, result_valid   : last completed count and its valid flag
//   result_ack             : consumer acknowledge
//   ovf, overrun, busy     : saturation flag, overwrite pulse, FSM not idle
//   peak_clr, cnt_min/max  : only with DCO_FREQ_METER_PEAK_EN defined
// Modports: slave = the meter, master = the consumer.
interface dco_freq_meter_if #(
  parameter int CNT_W = 12
);
  import dco_meas_pkg::*;

  logic                  start;
  logic                  cont;
  logic [GATE_SEL_W-1:0] gate_sel;
  logic [CNT_W-1:0]      result;
  logic                  result_valid;
  logic                  result_ack;
  logic                  ovf;
  logic                  overrun;
  logic                  busy;
`ifdef DCO_FREQ_METER_PEAK_EN
  logic                  peak_clr;
  logic [CNT_W-1:0]      cnt_min;
  logic [CNT_W-1:0]      cnt_max;
`endif

  modport slave (
    input  start, cont, gate_sel, result_ack,
    output result, result_valid, ovf, overrun, busy
`ifdef DCO_FREQ_METER_PEAK_EN
    , input  peak_clr
    , output cnt_min, cnt_max
`endif
  );

  modport master (
    output start, cont, gate_sel, result_ack,
    input  result, result_valid, ovf, overrun, busy
`ifdef DCO_FREQ_METER_PEAK_EN
    , output peak_clr
    , input  cnt_min, cnt_max
`endif
  );

endinterface

// File: rtl/dco_freq_meter_edge_sync.sv
// dco_edge_sync: brings an asynchronous DCO tap into the clk domain through
// SYNC_STAGES flops plus one delay flop and emits a one-cycle pulse on each
// synchronised 0->1 transition.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_i    : asynchronous input (DCO output)
//   edge_o     : rising-edge pulse in the clk domain
// Inputs faster than fclk/2 alias; that is not detected here.
module dco_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts DCO rising edges over a gate window of
// 2^(GATE_LOG2+gate_sel) clk cycles and presents the count with a
// valid/ack handshake.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ena        : design enable; low forces IDLE and clears result_valid
//   osc_in     : DCO output, asynchronous to clk
//   bus        : dco_freq_meter_if.slave (control, result, status)
// Optional: define DCO_FREQ_METER_PEAK_EN to add min/max tracking of results
// (bus.cnt_min, bus.cnt_max, bus.peak_clr).
//
// state  | meaning
// IDLE   | waiting for start; gate_sel latched on exit
// SETTLE | SYNC_STAGES cycles flushing stale synchroniser data; counters cleared
// COUNT  | N gate cycles, synchronised rising edges counted (saturating)
// DONE   | one cycle: publish result, then re-arm (cont) or return to IDLE
module dco_freq_meter
  import dco_meas_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int GATE_LOG2   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               osc_in,
  dco_freq_meter_if.slave    bus
);

  localparam int WIN_W = GATE_LOG2 + 4;
  localparam int SET_W = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;

  meas_state_e           state_q, state_d;
  logic [GATE_SEL_W-1:0] gsel_q;
  logic [SET_W-1:0]      settle_q;
  logic [WIN_W-1:0]      win_q;
  logic [WIN_W-1:0]      win_last;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sat_q;
  logic [CNT_W-1:0]      result_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  overrun_q;
  logic                  osc_edge;

  logic busy, arm, settle_st, count_st, done_st, settle_load;

  dco_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_in),
    .edge_o  (osc_edge)
  );

  assign win_last = WIN_W'(gate_len(GATE_LOG2, gsel_q) - 32'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start) state_d = SETTLE;
        SETTLE:  if (settle_q == '0) state_d = COUNT;
        COUNT:   if (win_q == win_last) state_d = DONE;
        DONE:    state_d = bus.cont ? SETTLE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / strobe decode
  always_comb begin
    busy        = (state_q != IDLE);
    arm         = ena && (state_q == IDLE) && bus.start;
    settle_st   = (state_q == SETTLE);
    count_st    = (state_q == COUNT);
    done_st     = ena && (state_q == DONE);
    settle_load = (state_d == SETTLE) && (state_q != SETTLE);
  end

  // Gate select is frozen for the whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   gsel_q <= '0;
    else if (arm) gsel_q <= bus.gate_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              settle_q <= '0;
    else if (settle_load)    settle_q <= SET_W'(SYNC_STAGES - 1);
    else if (settle_st)      settle_q <= settle_q - 1'b1;
  end

  // sat_q records an edge lost at full scale; the count itself never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (settle_st) begin
      win_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (count_st) begin
      win_q <= win_q + 1'b1;
      if (osc_edge) begin
        if (&cnt_q) sat_q <= 1'b1;
        else        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // DONE takes priority over a same-cycle ack, so fresh data is never dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (!ena) begin
        valid_q <= 1'b0;
      end else if (done_st) begin
        result_q  <= cnt_q;
        ovf_q     <= sat_q;
        valid_q   <= 1'b1;
        overrun_q <= valid_q & ~bus.result_ack;
      end else if (bus.result_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef DCO_FREQ_METER_PEAK_EN
  logic [CNT_W-1:0] min_q, max_q;

  // A clear coinciding with DONE restarts tracking from the new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else if (bus.peak_clr && done_st) begin
      min_q <= cnt_q;
      max_q <= cnt_q;
    end else if (bus.peak_clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (done_st) begin
      if (cnt_q < min_q) min_q <= cnt_q;
      if (cnt_q > max_q) max_q <= cnt_q;
    end
  end

  assign bus.cnt_min = min_q;
  assign bus.cnt_max = max_q;
`endif

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.ovf          = ovf_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_dco_freq_meter.sv
module tb_dco_freq_meter;
  import dco_meas_pkg::*;

  localparam int CNT_W     = 8;
  localparam int GATE_LOG2 = 8;
  localparam int SYNC      = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic ena    = 1'b0;
  logic osc_in = 1'b0;

  dco_freq_meter_if #(.CNT_W(CNT_W)) bus ();

  dco_freq_meter #(
    .CNT_W       (CNT_W),
    .GATE_LOG2   (GATE_LOG2),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .osc_in (osc_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Square wave of osc_per clk cycles, changed on the falling edge.
  int osc_per = 0;
  int osc_ph  = 0;
  always @(negedge clk) begin
    if (osc_per == 0) begin
      osc_ph = 0;
      osc_in = 1'b0;
    end else begin
      osc_ph = (osc_ph + 1) % osc_per;
      osc_in = (osc_ph < osc_per / 2);
    end
  end

  typedef struct {
    logic [CNT_W-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Advance n clock cycles, ending on a falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.result_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic ack_once();
    bus.result_ack = 1'b1;
    tick(1);
    bus.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if (bus.result !== '0 || bus.result_valid !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got res=%0d v=%b ovf=%b ovr=%b busy=%b expected all 0",
               bus.result, bus.result_valid, bus.ovf, bus.overrun, bus.busy);
    end
`ifdef DCO_FREQ_METER_PEAK_EN
    n_cmp++;
    if (bus.cnt_min !== 8'hFF || bus.cnt_max !== 8'h00) begin
      n_err++;
      $display("FAIL reset_peak: got min=%0d max=%0d expected 255/0", bus.cnt_min, bus.cnt_max);
    end
`endif
    rst_n = 1'b1;
    ena   = 1'b1;
    tick(2);
  endtask

  task automatic test_single_shot();
    int   n;
    exp_t e;
    osc_per      = 8;
    bus.gate_sel = 2'd0;
    bus.cont     = 1'b0;
    tick(4);
    sb.push_back('{res: 8'd32, ovf: 1'b0});
    pulse_start();
    wait_valid(400, n);
    n_cmp++;
    if (n !== SYNC + 256 + 1) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles expected %0d", n, SYNC + 256 + 1);
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.result !== e.res || bus.ovf !== e.ovf) begin
      n_err++;
      $display("FAIL single_result: got %0d/ovf=%b expected %0d/ovf=%b", bus.result, bus.ovf, e.res, e.ovf);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b expected 0", bus.busy);
    end
    tick(3);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_hold: got valid=%b expected 1", bus.result_valid);
    end
    ack_once();
    n_cmp++;
    if (bus.result_valid !== 1'b0 || bus.result !== 8'd32) begin
      n_err++;
      $display("FAIL single_ack: got valid=%b res=%0d expected 0/32", bus.result_valid, bus.result);
    end
  endtask

  task automatic test_window_select();
    int   n;
    exp_t e;
    osc_per      = 16;
    bus.gate_sel = 2'd3;
    tick(2);
    sb.push_back('{res: 8'd128, ovf: 1'b0});
    pulse_start();
    tick(500);
    bus.gate_sel = 2'd0;
    wait_valid(3000, n);
    n_cmp++;
    if (500 + n !== SYNC + 2048 + 1) begin
      n_err++;
      $display("FAIL window_latency: got %0d cycles expected %0d", 500 + n, SYNC + 2048 + 1);
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.result !== e.res || bus.ovf !== e.ovf) begin
      n_err++;
      $display("FAIL window_result: got %0d/ovf=%b expected %0d/ovf=%b", bus.result, bus.ovf, e.res, e.ovf);
    end
    ack_once();
  endtask

  task automatic test_saturation();
    int   n;
    exp_t e;
    osc_per      = 2;
    bus.gate_sel = 2'd3;
    tick(2);
    sb.push_back('{res: 8'd255, ovf: 1'b1});
    pulse_start();
    wait_valid(2200, n);
    e = sb.pop_front();
    n_cmp++;
    if (n >= 2200 || bus.result !== e.res || bus.ovf !== e.ovf) begin
      n_err++;
      $display("FAIL saturation: got %0d/ovf=%b after %0d cycles expected %0d/ovf=%b",
               bus.result, bus.ovf, n, e.res, e.ovf);
    end
    ack_once();
  endtask

  task automatic test_continuous();
    exp_t e;
    osc_per      = 4;
    bus.gate_sel = 2'd0;
    bus.cont     = 1'b1;
    tick(2);
    repeat (4) sb.push_back('{res: 8'd64, ovf: 1'b0});
    pulse_start();
    tick(259);
    e = sb.pop_front();
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.result !== e.res || bus.ovf !== e.ovf || bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL cont_first: got v=%b res=%0d ovr=%b expected 1/%0d/0",
               bus.result_valid, bus.result, bus.overrun, e.res);
    end
    tick(259);
    e = sb.pop_front();
    n_cmp++;
    if (bus.result !== e.res || bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL cont_second: got res=%0d ovr=%b expected %0d/1", bus.result, bus.overrun, e.res);
    end
    tick(1);
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL cont_pulse_width: got ovr=%b expected 0", bus.overrun);
    end
    tick(258);
    e = sb.pop_front();
    n_cmp++;
    if (bus.result !== e.res || bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL cont_third: got res=%0d ovr=%b expected %0d/1", bus.result, bus.overrun, e.res);
    end
    // Ack lands in the DONE cycle of the fourth window.
    tick(258);
    bus.result_ack = 1'b1;
    tick(1);
    bus.result_ack = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.result !== e.res) begin
      n_err++;
      $display("FAIL cont_ack_done: got v=%b ovr=%b res=%0d expected 1/0/%0d",
               bus.result_valid, bus.overrun, bus.result, e.res);
    end
  endtask

  task automatic test_ena_drop();
    tick(100);
    ena = 1'b0;
    tick(1);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 8'd64) begin
      n_err++;
      $display("FAIL ena_drop: got busy=%b v=%b res=%0d expected 0/0/64",
               bus.busy, bus.result_valid, bus.result);
    end
    tick(300);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ena_no_done: got busy=%b v=%b ovr=%b expected 0/0/0",
               bus.busy, bus.result_valid, bus.overrun);
    end
    ena = 1'b1;
    tick(2);
  endtask

  task automatic test_cont_clear();
    int   n;
    exp_t e;
    osc_per      = 8;
    bus.cont     = 1'b1;
    bus.gate_sel = 2'd0;
    sb.push_back('{res: 8'd32, ovf: 1'b0});
    pulse_start();
    tick(100);
    bus.cont = 1'b0;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_valid(400, n);
    e = sb.pop_front();
    n_cmp++;
    if (101 + n !== SYNC + 256 + 1 || bus.result !== e.res || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL cont_clear: got lat=%0d res=%0d busy=%b expected %0d/%0d/0",
               101 + n, bus.result, bus.busy, SYNC + 256 + 1, e.res);
    end
    tick(300);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL cont_clear_idle: got busy=%b ovr=%b expected 0/0", bus.busy, bus.overrun);
    end
  endtask

`ifdef DCO_FREQ_METER_PEAK_EN
  task automatic test_peak();
    int n;
    ack_once();
    bus.peak_clr = 1'b1;
    tick(1);
    bus.peak_clr = 1'b0;
    bus.gate_sel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      osc_per = (i == 0) ? 8 : 4;
      tick(2);
      pulse_start();
      wait_valid(400, n);
      ack_once();
    end
    n_cmp++;
    if (bus.cnt_min !== 8'd32 || bus.cnt_max !== 8'd64) begin
      n_err++;
      $display("FAIL peak_track: got min=%0d max=%0d expected 32/64", bus.cnt_min, bus.cnt_max);
    end
    bus.peak_clr = 1'b1;
    tick(1);
    bus.peak_clr = 1'b0;
    n_cmp++;
    if (bus.cnt_min !== 8'hFF || bus.cnt_max !== 8'h00) begin
      n_err++;
      $display("FAIL peak_clr: got min=%0d max=%0d expected 255/0", bus.cnt_min, bus.cnt_max);
    end
  endtask
`endif

  task automatic test_reset_mid();
    osc_per      = 8;
    bus.gate_sel = 2'd0;
    pulse_start();
    tick(100);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.result !== '0 || bus.result_valid !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got res=%0d v=%b ovf=%b ovr=%b busy=%b expected all 0",
               bus.result, bus.result_valid, bus.ovf, bus.overrun, bus.busy);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b v=%b expected 0/0", bus.busy, bus.result_valid);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.cont       = 1'b0;
    bus.gate_sel   = 2'd0;
    bus.result_ack = 1'b0;
`ifdef DCO_FREQ_METER_PEAK_EN
    bus.peak_clr   = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_window_select();
    test_saturation();
    test_continuous();
    test_ena_drop();
    test_cont_clear();
`ifdef DCO_FREQ_METER_PEAK_EN
    test_peak();
`endif
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dco_freq_meter.md
Name: dco_freq_meter

Overview:
- Measures the output frequency of the on-chip DCO by counting its rising edges over a programmable gate window of the system clock.
- The DCO converts a code into a frequency. This block converts that frequency back into a count, closing the loop for characterisation and future code calibration.
- Sits beside the DCO inside the tt_um top level. Its result is read out through uo_out/uio by the top-level mux.

Parameters:
- CNT_W, 12: result/counter width in bits; the counter saturates at 2^CNT_W-1.
- GATE_LOG2, 8: base gate length exponent; window = 2^(GATE_LOG2+gate_sel) clk cycles.
- SYNC_STAGES, 2: synchroniser depth on osc_in, must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low = synchronous return to IDLE, result_valid cleared
- osc_in  in  1  DCO output, asynchronous to clk
- start  in  1  request a measurement; sampled in IDLE only
- cont  in  1  continuous mode: re-arm automatically after each window
- gate_sel  in  2  window select, 0..3
- result  out  CNT_W  rising-edge count of the last completed window
- result_valid  out  1  result holds unacknowledged data
- result_ack  in  1  consumer acknowledge
- ovf  out  1  last window saturated
- overrun  out  1  one-cycle pulse: a valid result was overwritten before it was acked
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; result=0; result_valid=0; ovf=0; overrun=0; busy=0; synchroniser and edge flop=0.
- osc_in passes through SYNC_STAGES flops, then one delay flop.
- An edge is a synced 0->1 transition (s & ~s_d).
- Maximum measurable frequency is fclk/2. Faster inputs alias; this is documented, not detected.
- State machine:
  - IDLE: start=1 & ena=1 -> SETTLE. gate_sel is latched into gsel_q on this edge; gate_sel changes mid-window are ignored.
  - SETTLE: lasts SYNC_STAGES cycles and discards stale synchroniser contents. Counter and window timer are cleared. Then -> COUNT.
  - COUNT: lasts exactly N = 2^(GATE_LOG2+gsel_q) cycles. Edges detected in these N cycles are counted. The counter saturates at all-ones; it never wraps.
  - DONE (single cycle): result<=count; ovf<=(saturation occurred); result_valid<=1; overrun pulses if result_valid was already 1 without a same-cycle ack. Then -> SETTLE if cont=1, else -> IDLE.
- Latency: start sampled at edge 0 -> result_valid high after edge SYNC_STAGES+N+1. In continuous mode, windows repeat every SYNC_STAGES+N+1 cycles.
- Handshake:
  - result_valid stays high until a cycle with result_ack=1, then clears on the next edge.
  - If ack and DONE coincide, DONE wins: valid stays 1, new data is loaded, no overrun.
  - result is stable while valid=1 unless overwritten by DONE.
  - An ack while valid=0 is ignored.
- start while busy: ignored. Clearing cont mid-window lets the current window finish, then the block goes to IDLE.
- ena falling mid-operation: next edge forces IDLE, clears result_valid and discards the partial count. result keeps its last value.
- Window timer width: GATE_LOG2+4 bits, compared against N-1.

Optional Feature:
- Macro: DCO_FREQ_METER_PEAK_EN.
- When defined:
  - Adds outputs cnt_min and cnt_max (CNT_W each) and input peak_clr.
  - Each DONE updates min/max with the new result.
  - Reset and peak_clr set cnt_min=all-ones and cnt_max=0.
  - peak_clr coinciding with DONE: clear takes priority, and then the new result is applied, so min=max=result.
- When undefined: the ports and logic are absent, and core behaviour is identical.

Decomposition:
- Package dco_meas_pkg holds:
  - state enum {IDLE, SETTLE, COUNT, DONE};
  - GATE_SEL_W=2;
  - the gate-length function gate_len(log2, sel).
- One natural sub-module: dco_edge_sync (SYNC_STAGES synchroniser plus rising-edge pulse). It is reusable for the other async DCO taps.

Test Plan:
- In all scenarios the bench generates osc_in as a square wave derived from clk, so counts are exact.
- Reset/idle: rst_n=0 mid-COUNT -> all outputs 0 immediately; after release busy=0 and result_valid=0.
- Single shot: osc period 8 clk, gate_sel=0, start pulse -> result_valid rises exactly 2+256+1 cycles after start; result=32, ovf=0; cleared by result_ack.
- Window select: osc period 16, gate_sel=3 -> result=128. Change gate_sel mid-window -> result still 128.
- Saturation: CNT_W=8, osc period 2, gate_sel=3 -> 1024 edges -> result=255, ovf=1.
- Continuous/overrun: cont=1, osc period 4, gate_sel=0, no ack -> each window result=64. overrun pulses at the second and later DONEs. Ack in the same cycle as DONE -> no overrun, valid stays 1.
- ena drop: ena=0 mid-COUNT -> IDLE next cycle, result_valid=0, no DONE. With DCO_FREQ_METER_PEAK_EN, periods 8 then 4 -> cnt_min=32, cnt_max=64; then peak_clr -> all-ones/0.
